// File: rtl/scan_pkg.sv
// Shared definitions for the internal scan-chain master: FSM encoding,
// frame geometry and the TMS level used in each shift phase.
package scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  localparam int FRAME_BITS = 16;

  // Index of the last bit within one phase (address or data).
  localparam logic [2:0] BIT_LAST = 3'(FRAME_BITS / 2 - 1);

  localparam logic ADDR_TMS = 1'b1;
  localparam logic DATA_TMS = 1'b0;

endpackage

// File: rtl/tck_divider.sv
// Generates the scan clock from clk: DIV cycles low, then DIV cycles high,
// plus strobes marking the first low cycle and the last high cycle.
module tck_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam logic [7:0] HALF_LAST = 8'(DIV - 1);

  logic [7:0] half_cnt;
  logic       phase;
  logic       half_end;

  assign half_end = (half_cnt == HALF_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= 8'd0;
      phase    <= 1'b0;
    end else if (!run) begin
      half_cnt <= 8'd0;
      phase    <= 1'b0;
    end else if (half_end) begin
      half_cnt <= 8'd0;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

  assign tck      = phase;
  assign fall_stb = run && !phase && (half_cnt == 8'd0);
  assign rise_stb = run && phase && half_end;

endmodule

// File: rtl/scan_sequencer.sv
// Internal scan-chain master: each frame shifts an address byte (tms=1) then a
// data byte (tms=0) into the tap chain, capturing the returned byte from tdo.
//
// state   | meaning
// IDLE    | chain quiet, waiting for enable to start a frame
// ADDR    | shifting the latched address, LSB first, tms=1
// DATA    | shifting the latched pin data, capturing tdo, tms=0
// GAP     | quiet TCK periods between frames, tck held low
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int GAP   = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] i_pins,
  input  logic             tdo,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  output logic [WIDTH-1:0] o_pins,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP);

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_nxt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] pins_q;
  logic [WIDTH-1:0] capture;
  logic             run;
  logic             tck_raw;
  logic             fall_stb;
  logic             rise_stb;

  assign run     = (state != ST_IDLE);
  assign busy    = run;
  assign bit_nxt = bit_cnt + 3'd1;

  // The divider keeps running through GAP so its strobes can time the gap;
  // the chain must not see those edges.
  assign tck = tck_raw & (state != ST_GAP);

  tck_divider #(
    .DIV(DIV)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .tck      (tck_raw),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      gap_cnt    <= 4'd0;
      addr_q     <= '0;
      pins_q     <= '0;
      capture    <= '0;
      o_pins     <= '0;
      tms        <= 1'b0;
      tdi        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Holding off for the frame_done cycle guarantees busy is seen low
          // for one cycle between frames even when there is no gap.
          if (enable && !frame_done) begin
            addr_q  <= addr;
            pins_q  <= i_pins;
            bit_cnt <= 3'd0;
            tms     <= ADDR_TMS;
            tdi     <= addr[0];
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rise_stb) begin
            bit_cnt <= bit_nxt;
            if (bit_cnt == BIT_LAST) begin
              tms   <= DATA_TMS;
              tdi   <= pins_q[0];
              state <= ST_DATA;
            end else begin
              tdi <= addr_q[bit_nxt];
            end
          end
        end
        ST_DATA: begin
          if (rise_stb) begin
            capture[bit_cnt] <= tdo;
            bit_cnt          <= bit_nxt;
            if (bit_cnt == BIT_LAST) begin
              o_pins     <= {tdo, capture[WIDTH-2:0]};
              frame_done <= 1'b1;
              tdi        <= 1'b0;
              if (GAP == 0) begin
                state <= ST_IDLE;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= ST_GAP;
              end
            end else begin
              tdi <= pins_q[bit_nxt];
            end
          end
        end
        ST_GAP: begin
          // Periods are counted as they begin; leave at the end of the last one.
          if (fall_stb && (gap_cnt != 4'd0)) begin
            gap_cnt <= gap_cnt - 4'd1;
          end
          if (rise_stb && (gap_cnt == 4'd0)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a DIV=1/GAP=2 instance for frame content
// and sequencing, and a DIV=3/GAP=0 instance for timing.
module tb_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic [7:0] addr    = 8'h00;
  logic [7:0] i_pins  = 8'h00;
  logic       tdo     = 1'b0;
  logic       tck, tms, tdi, busy, frame_done;
  logic [7:0] o_pins;

  logic       rst3_n  = 1'b0;
  logic       enable3 = 1'b0;
  logic [7:0] addr3   = 8'h81;
  logic [7:0] i_pins3 = 8'h42;
  logic       tdo3    = 1'b1;
  logic       tck3, tms3, tdi3, busy3, frame_done3;
  logic [7:0] o_pins3;

  int total = 0;
  int bad   = 0;

  logic [7:0] ret_byte = 8'h00;
  int         dbit      = 0;
  int         tck_edges = 0;
  logic [1:0] bits_q[$];

  scan_sequencer #(.DIV(1), .GAP(2), .WIDTH(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .addr(addr),
    .i_pins(i_pins), .tdo(tdo), .tck(tck), .tms(tms), .tdi(tdi),
    .o_pins(o_pins), .busy(busy), .frame_done(frame_done)
  );

  scan_sequencer #(.DIV(3), .GAP(0), .WIDTH(8)) u_dut3 (
    .clk(clk), .reset_n(rst3_n), .enable(enable3), .addr(addr3),
    .i_pins(i_pins3), .tdo(tdo3), .tck(tck3), .tms(tms3), .tdi(tdi3),
    .o_pins(o_pins3), .busy(busy3), .frame_done(frame_done3)
  );

  // Chain model: record what is shifted on each rising tck and present the
  // return byte LSB first during the data phase.
  always @(posedge tck) begin
    tck_edges++;
    bits_q.push_back({tms, tdi});
    if (tms) begin
      dbit = 0;
    end else begin
      tdo = ret_byte[dbit[2:0]];
      dbit++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    bit to;
    to = 1'b1;
    n  = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) begin
        to = 1'b0;
        break;
      end
    end
    chk("done_timeout", 32'(to), 0);
  endtask

  task automatic wait_start(output int n);
    bit seen_low;
    bit to;
    seen_low = !busy;
    to       = 1'b1;
    n        = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (!busy) begin
        seen_low = 1'b1;
      end else if (seen_low) begin
        to = 1'b0;
        break;
      end
    end
    chk("start_timeout", 32'(to), 0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] ea, input logic [7:0] ed);
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] t;
    a = '0;
    d = '0;
    t = '0;
    chk({tag, "_nbits"}, bits_q.size(), 16);
    if (bits_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        t[i] = bits_q[i][1];
        if (i < 8) a[i] = bits_q[i][0];
        else       d[i-8] = bits_q[i][0];
      end
      chk({tag, "_addr"}, 32'(a), 32'(ea));
      chk({tag, "_data"}, 32'(d), 32'(ed));
      chk({tag, "_tms"},  32'(t), 'h00FF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int edges;
    int cnt_done;
    int cnt_busy;
    int done_at;
    logic [11:0] tpat;

    // 1: reset with enable held high
    enable   = 1'b1;
    addr     = 8'h05;
    i_pins   = 8'hA3;
    ret_byte = 8'h3C;
    enable3  = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_rst_out", 32'({o_pins, tck, tms, tdi, busy, frame_done}), 0);
    chk("t1_rst_out3", 32'({o_pins3, tck3, tms3, tdi3, busy3, frame_done3}), 0);
    bits_q.delete();
    reset_n = 1'b1;
    wait_start(n);
    chk("t1_busy_first_edge", n, 1);
    chk("t1_tms_addr", 32'(tms), 1);
    chk("t1_tdi_bit0", 32'(tdi), 1);

    // 2: basic frame
    wait_done(n);
    chk("t2_latency", n, 32);
    chk("t2_o_pins", 32'(o_pins), 'h3C);
    check_frame("t2", 8'h05, 8'hA3);
    @(negedge clk);
    chk("t2_done_pulse", 32'(frame_done), 0);
    chk("t2_gap_busy", 32'(busy), 1);
    chk("t2_gap_tck", 32'(tck), 0);
    wait_start(n);
    chk("t2_gap_len", n, 4);

    // 3: input change during ADDR takes effect on the next frame only
    bits_q.delete();
    ret_byte = 8'h5A;
    repeat (3) @(negedge clk);
    addr   = 8'h02;
    i_pins = 8'hFF;
    wait_done(n);
    chk("t3a_o_pins", 32'(o_pins), 'h5A);
    check_frame("t3a", 8'h05, 8'hA3);
    wait_start(n);
    bits_q.delete();
    ret_byte = 8'h96;
    wait_done(n);
    chk("t3b_o_pins", 32'(o_pins), 'h96);
    check_frame("t3b", 8'h02, 8'hFF);

    // 4: disable during DATA
    wait_start(n);
    bits_q.delete();
    ret_byte = 8'h0F;
    repeat (20) @(negedge clk);
    chk("t4_in_data", 32'(tms), 0);
    enable = 1'b0;
    wait_done(n);
    chk("t4_o_pins", 32'(o_pins), 'h0F);
    check_frame("t4", 8'h02, 8'hFF);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
    chk("t4_busy_fall", n, 4);
    edges = tck_edges;
    repeat (40) @(negedge clk);
    chk("t4_no_tck", tck_edges, edges);
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_hold_o_pins", 32'(o_pins), 'h0F);

    // 5: async reset at DATA bit 3
    ret_byte = 8'h3C;
    enable   = 1'b1;
    wait_start(n);
    wait_done(n);
    chk("t5_pre_o_pins", 32'(o_pins), 'h3C);
    wait_start(n);
    repeat (22) @(negedge clk);
    chk("t5_in_data", 32'(tms), 0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_o_pins", 32'(o_pins), 0);
    chk("t5_rst_tck", 32'(tck), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done) cnt_done++;
      if (busy) cnt_busy++;
    end
    chk("t5_no_done", cnt_done, 0);
    chk("t5_no_busy", cnt_busy, 0);
    chk("t5_o_pins_cleared", 32'(o_pins), 0);

    // 6: DIV=3, GAP=0 timing
    @(negedge clk);
    rst3_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (busy3) break;
    end
    chk("t6_busy_first_edge", n, 1);
    chk("t6_tms_addr", 32'(tms3), 1);
    chk("t6_tdi_bit0", 32'(tdi3), 1);
    tpat    = '0;
    done_at = -1;
    for (int k = 0; k < 400; k++) begin
      if (k < 12) tpat[k] = tck3;
      if (frame_done3) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    chk("t6_tck_pattern", 32'(tpat), 'hE38);
    chk("t6_latency", done_at, 96);
    chk("t6_o_pins", 32'(o_pins3), 'hFF);
    @(negedge clk);
    chk("t6_done_pulse", 32'(frame_done3), 0);
    chk("t6_idle_busy", 32'(busy3), 0);
    @(negedge clk);
    chk("t6_restart", 32'(busy3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Internal scan-chain master that drives the TCK/TMS/TDI inputs of the tap chain when MODE=0.
- Repeatedly shifts a frame into the chain: an 8-bit project address, then 8 bits of input-pin data.
- While shifting the data bits, it captures 8 bits returned on TDO from the end of the chain and presents them as o_pins.
- Sits directly upstream of tap instance 1 and consumes td[NUM_DESIGNS] from the last tap.

Parameters:
- DIV, 4: clk cycles per TCK half-period; legal range 1..255.
- GAP, 2: idle TCK periods between frames; legal range 0..15.
- WIDTH, 8: address width and data width in bits; fixed at 8 for TT03.

Ports:
- clk  input  1  system clock (uart_clk domain).
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  run frames continuously while high.
- addr  input  8  project select, sampled at frame start.
- i_pins  input  8  data shifted to the selected project, sampled at frame start.
- tdo  input  1  serial return from the end of the chain.
- tck  output  1  scan clock to the chain.
- tms  output  1  1 during the address phase, 0 otherwise.
- tdi  output  1  serial data to the chain.
- o_pins  output  8  last captured return byte.
- busy  output  1  high while a frame or its gap is in progress.
- frame_done  output  1  one-cycle pulse when o_pins updates.

Behaviour:
- Reset (async assert, sync release): tck=0, tms=0, tdi=0, o_pins=0, busy=0, frame_done=0, state=IDLE, all counters cleared.
- Reset mid-frame aborts the frame immediately. No partial o_pins update occurs.
- States: IDLE, ADDR, DATA, GAP.
- IDLE: outputs are tck=0, tms=0, tdi=0.
  - If enable=1 on a clk edge: latch addr and i_pins, set busy=1, set bit counter to 0, go to ADDR.
- Bit timing (ADDR and DATA):
  - Each bit is one TCK period of 2*DIV clk cycles: DIV cycles with tck=0, then DIV cycles with tck=1.
  - tms and tdi are updated on the first cycle of the low half, so they are stable before the rising tck edge.
  - tdo is sampled on the last clk cycle of the high half.
- ADDR: 8 bits, tms=1, tdi=addr_latched[bit], LSB first. tdo is ignored. After bit 7, go to DATA.
- DATA: 8 bits, tms=0, tdi=i_pins_latched[bit], LSB first.
  - Each sampled tdo shifts into capture[bit]; the first sampled bit becomes capture[0].
  - After bit 7: o_pins <= capture, frame_done=1 for exactly one cycle, then go to GAP.
  - Latency: frame_done asserts 16*2*DIV clk cycles after the cycle busy rises.
- GAP: tck=0, tms=0, tdi=0 for GAP*2*DIV cycles. Then go to IDLE and drop busy for one cycle, so a new frame starts on the next qualifying edge.
  - GAP=0: go from DATA straight to IDLE.
- enable deasserted mid-frame: the current frame and its gap complete normally, then the block stays in IDLE.
- Changes to addr or i_pins mid-frame have no effect until the next frame start.
- o_pins holds its value between frames and while disabled.
- Counters:
  - Half-period counter: 8 bits, counts 0..DIV-1 and wraps.
  - Bit counter: 3 bits, wraps 7->0 at each phase change.
  - Gap counter: 4 bits plus half-period reuse.
  - No counter overflows at the legal parameter limits.

Decomposition:
- Shared package scan_pkg holds:
  - state enum {IDLE, ADDR, DATA, GAP};
  - FRAME_BITS=16;
  - ADDR_TMS=1'b1, DATA_TMS=1'b0.
- Sub-module tck_divider(clk, reset_n, run, tck, fall_stb, rise_stb) generates tck and one-cycle strobes:
  - fall_stb: start of the low half (drive tms/tdi);
  - rise_stb: last cycle of the high half (sample tdo, advance bit).
- scan_sequencer contains the FSM, latches, shift registers and output registers.

Test Plan:
1. Reset: hold reset_n=0 with enable=1 -> all outputs 0, busy=0. Release reset -> busy rises on the first edge and the frame begins.
2. Basic frame, DIV=1, GAP=2, addr=0x05, i_pins=0xA3, chain model returns 0x3C LSB first:
   - tdi address bits = 1,0,1,0,0,0,0,0 with tms=1;
   - data bits = 1,1,0,0,0,1,0,1 with tms=0;
   - frame_done pulses 32 cycles after busy rises; o_pins=0x3C.
3. Input change mid-frame: change addr to 0x02 and i_pins to 0xFF during ADDR -> current frame still shifts 0x05/0xA3; the next frame shifts 0x02/0xFF.
4. Disable mid-frame: drop enable during DATA -> frame completes, o_pins updates, gap runs, busy falls, no further tck edges.
5. Async reset mid-frame: assert reset_n=0 at DATA bit 3 with o_pins previously 0x3C -> o_pins=0 immediately, tck=0, no frame_done pulse.
6. Timing with DIV=3, GAP=0: tck high and low for 3 cycles each; frame_done 96 cycles after busy rises; the next frame's busy rises 2 cycles after frame_done.
